// File: rtl/mmio_capture.sv
// mmio_capture: watches CPU stores to N_PORTS consecutive word addresses
// starting at BASE_ADDR and queues {port, data} into a first-word-fall-through
// FIFO. A store to HALT_PORT, or TIMEOUT running cycles, stops further capture.
// The FIFO can still be drained after capture has stopped.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   memwrite/dataadr/       CPU store strobe, byte address and data
//   writedata
//   rd_en                   pop request; ignored while empty
//   rd_data/rd_port         head-of-FIFO entry, valid while empty=0
//   empty/full/count        FIFO occupancy
//   overflow                sticky: a capture was dropped because the FIFO was full
//   halted                  sticky: a halt-port store was captured
//   timeout                 sticky: TIMEOUT cycles elapsed without a halt
//   cycle_count             running cycles since reset
module mmio_capture #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned HALT_PORT = 0,
  parameter int unsigned TIMEOUT   = 1000,
  localparam int unsigned PW = $clog2(N_PORTS),
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [PW-1:0]    rd_port,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             halted,
  output logic             timeout,
  output logic [31:0]      cycle_count
);

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]    mem_port [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  logic          addr_hit;
  logic [PW-1:0] hit_port;
  logic          running;
  logic          capture;
  logic          do_pop;
  logic          do_push;
  logic          drop;
  logic          halt_hit;
  logic          tick_to;

  // Decode the store address against every watched word address.
  always_comb begin
    addr_hit = 1'b0;
    hit_port = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (dataadr == WIDTH'(BASE_ADDR + 4 * i)) begin
        addr_hit = 1'b1;
        hit_port = PW'(i);
      end
    end
  end

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign running  = ~halted & ~timeout;
  assign capture  = memwrite & addr_hit & running;
  assign do_pop   = rd_en & ~empty;
  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign do_push  = capture & (~full | do_pop);
  assign drop     = capture & full & ~do_pop;
  assign halt_hit = capture & (hit_port == PW'(HALT_PORT));
  assign tick_to  = (cycle_count == 32'(TIMEOUT - 1));

  assign rd_data = mem_data[rd_ptr];
  assign rd_port = mem_port[rd_ptr];

  // Storage is not reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr] <= writedata;
      mem_port[wr_ptr] <= hit_port;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (halt_hit) begin
        halted <= 1'b1;
      end
      if (running) begin
        cycle_count <= cycle_count + 32'd1;
        // A halt on the same edge takes precedence over the timeout.
        if (tick_to && !halt_hit) begin
          timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_capture.sv
module tb_mmio_capture;

  localparam int NP     = 4;
  localparam int DEP    = 8;
  localparam int T_MAIN = 1000;
  localparam int HALTP  = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        rd_en = 1'b0;

  logic [31:0] rd_data;
  logic [1:0]  rd_port;
  logic        empty, full, overflow, halted, timeout;
  logic [3:0]  count;
  logic [31:0] cycle_count;

  logic [31:0] t_rd_data;
  logic [1:0]  t_rd_port;
  logic        t_empty, t_full, t_overflow, t_halted, t_timeout;
  logic [3:0]  t_count;
  logic [31:0] t_cycle_count;

  mmio_capture #(.WIDTH(32), .N_PORTS(NP), .DEPTH(DEP), .BASE_ADDR(0), .HALT_PORT(HALTP),
                 .TIMEOUT(T_MAIN)) u_dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .rd_en(rd_en), .rd_data(rd_data), .rd_port(rd_port),
    .empty(empty), .full(full), .count(count), .overflow(overflow), .halted(halted),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  // Short-timeout instance sharing the same stimulus.
  mmio_capture #(.WIDTH(32), .N_PORTS(NP), .DEPTH(DEP), .BASE_ADDR(0), .HALT_PORT(HALTP),
                 .TIMEOUT(5)) u_to (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .rd_en(rd_en), .rd_data(t_rd_data), .rd_port(t_rd_port),
    .empty(t_empty), .full(t_full), .count(t_count), .overflow(t_overflow),
    .halted(t_halted), .timeout(t_timeout), .cycle_count(t_cycle_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Behavioural model of u_dut: a queue plus sticky flags.
  typedef struct {
    int          port;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          m_valid = 1'b0;
  bit          m_ovf, m_halt, m_to;
  int unsigned m_cc;

  function automatic int port_of(input logic [31:0] a);
    if (a[1:0] != 2'b00) return -1;
    if ((a >> 2) < NP) return int'(a >> 2);
    return -1;
  endfunction

  initial begin
    int p;
    bit cap, pop, run, hit;
    ent_t e;
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        m_ovf   = 0;
        m_halt  = 0;
        m_to    = 0;
        m_cc    = 0;
        m_valid = 1;
      end else begin
        p   = port_of(dataadr);
        run = !m_halt && !m_to;
        cap = memwrite && (p >= 0) && run;
        pop = rd_en && (mq.size() > 0);
        hit = cap && (p == HALTP);
        if (cap && mq.size() == DEP && !pop) m_ovf = 1;
        if (pop) void'(mq.pop_front());
        if (cap && (mq.size() < DEP)) begin
          e.port = p;
          e.data = writedata;
          mq.push_back(e);
        end
        if (hit) m_halt = 1;
        if (run) begin
          m_cc++;
          if (m_cc == T_MAIN && !hit) m_to = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == DEP));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("cycle_count", cycle_count, m_cc);
        if (mq.size() > 0) begin
          chk("rd_data", rd_data, mq[0].data);
          chk("rd_port", 32'(rd_port), 32'(mq[0].port));
        end
      end
    end
  end

  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic re);
    memwrite  = we;
    dataadr   = a;
    writedata = d;
    rd_en     = re;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
  endtask

  logic [31:0] ra;

  initial begin
    // Reset state
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_flags", {29'd0, overflow, halted, timeout}, 32'd0);
    chk("rst_cc", cycle_count, 32'd0);

    // Single capture on port 1
    cyc(1'b1, 32'h4, 32'h11, 1'b0);
    chk("p1_empty", 32'(empty), 32'd0);
    chk("p1_count", 32'(count), 32'd1);
    chk("p1_port", 32'(rd_port), 32'd1);
    chk("p1_data", rd_data, 32'h11);
    chk("p1_halted", 32'(halted), 32'd0);
    // Misaligned and out-of-range addresses are ignored
    cyc(1'b1, 32'h5, 32'h99, 1'b0);
    cyc(1'b1, 32'h10, 32'h98, 1'b0);
    chk("ign_count", 32'(count), 32'd1);

    // Overflow: 9 stores into an 8-deep FIFO, then drain
    do_reset();
    for (int i = 1; i <= 9; i++) cyc(1'b1, 32'h8, 32'(i), 1'b0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", rd_data, 32'(i));
      cyc(1'b0, 32'h0, 32'h0, 1'b1);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1);
    chk("pop_empty_count", 32'(count), 32'd0);

    // Capture and pop together while full
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h8, 32'h100 + 32'(i), 1'b0);
    cyc(1'b1, 32'hC, 32'hABC, 1'b1);
    chk("fp_count", 32'(count), 32'd8);
    chk("fp_ovf", 32'(overflow), 32'd0);
    chk("fp_head", rd_data, 32'h101);
    for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1);
    chk("fp_new_data", rd_data, 32'hABC);
    chk("fp_new_port", 32'(rd_port), 32'd3);
    chk("fp_count1", 32'(count), 32'd1);

    // Capture with rd_en while empty pushes only
    do_reset();
    cyc(1'b1, 32'hC, 32'h5A, 1'b1);
    chk("ep_count", 32'(count), 32'd1);

    // Reset mid-operation with occupancy 3 and overflow set
    do_reset();
    for (int i = 1; i <= 9; i++) cyc(1'b1, 32'h8, 32'(i), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1);
    chk("mid_count", 32'(count), 32'd3);
    chk("mid_ovf", 32'(overflow), 32'd1);
    reset = 1'b1;
    cyc(1'b1, 32'h4, 32'h77, 1'b1);
    reset = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);

    // Halt-port store
    do_reset();
    cyc(1'b1, 32'h0, 32'h2A, 1'b0);
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_count", 32'(count), 32'd1);
    chk("h_port", 32'(rd_port), 32'd0);
    chk("h_data", rd_data, 32'h2A);
    chk("h_cc", cycle_count, 32'd1);
    cyc(1'b1, 32'h4, 32'h33, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0);
    chk("h_ignored", 32'(count), 32'd1);
    chk("h_cc_frozen", cycle_count, 32'd1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1);
    chk("h_drain", 32'(empty), 32'd1);

    // Timeout on the short-timeout instance
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0);
    chk("to_before", 32'(t_timeout), 32'd0);
    chk("to_cc4", t_cycle_count, 32'd4);
    cyc(1'b0, 32'h0, 32'h0, 1'b0);
    chk("to_set", 32'(t_timeout), 32'd1);
    chk("to_cc5", t_cycle_count, 32'd5);
    cyc(1'b1, 32'h4, 32'h44, 1'b0);
    chk("to_ignored", 32'(t_empty), 32'd1);
    chk("to_cc_hold", t_cycle_count, 32'd5);

    // Halt and timeout on the same edge: halt wins
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 32'h0, 32'h77, 1'b0);
    chk("ht_halted", 32'(t_halted), 32'd1);
    chk("ht_timeout", 32'(t_timeout), 32'd0);
    chk("ht_count", 32'(t_count), 32'd1);
    chk("ht_data", t_rd_data, 32'h77);
    cyc(1'b0, 32'h0, 32'h0, 1'b0);
    chk("ht_timeout_late", 32'(t_timeout), 32'd0);
    chk("ht_cc", t_cycle_count, 32'd5);

    // Randomized segments checked by the model every cycle
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        case ($urandom_range(0, 15))
          0, 1, 2, 3: ra = 32'h4;
          4, 5, 6:    ra = 32'h8;
          7, 8, 9:    ra = 32'hC;
          10:         ra = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'h8;
          11:         ra = 32'h10;
          12:         ra = 32'h6;
          default:    ra = $urandom;
        endcase
        reset = ($urandom_range(0, 99) == 0);
        cyc(($urandom_range(0, 9) < 6), ra, $urandom, ($urandom_range(0, 9) < 4 + s % 3));
      end
      reset = 1'b0;
    end

    cyc(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mmio_capture.md
MMIO_CAPTURE -- requirements
Module: mmio_capture

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data and address width.
REQ-002 SHALL provide parameter N_PORTS, default 4, number of watched word addresses; legal range 2..16.
REQ-003 SHALL provide parameter DEPTH, default 8, capture FIFO entries; power of two, at least 2.
REQ-004 SHALL provide parameter BASE_ADDR, default 0, byte address of port 0.
REQ-005 SHALL provide parameter HALT_PORT, default 0, port index whose write halts capture.
REQ-006 SHALL provide parameter TIMEOUT, default 1000, cycle limit before timeout; at least 1.
REQ-007 SHALL have ports, in this order:
  clk  input  1  single clock, all state updates on rising edge
  reset  input  1  synchronous, active-high reset
  memwrite  input  1  CPU store strobe
  dataadr  input  WIDTH  CPU store byte address
  writedata  input  WIDTH  CPU store data
  rd_en  input  1  pop request for the capture FIFO
  rd_data  output  WIDTH  data at FIFO head
  rd_port  output  clog2(N_PORTS)  port index at FIFO head
  empty  output  1  FIFO holds no entries
  full  output  1  FIFO holds DEPTH entries
  count  output  clog2(DEPTH+1)  FIFO occupancy
  overflow  output  1  sticky, a capture was dropped
  halted  output  1  sticky, halt-port write seen
  timeout  output  1  sticky, TIMEOUT cycles elapsed without halt
  cycle_count  output  32  cycles since reset while running

Function
REQ-008 Port i SHALL match when dataadr == BASE_ADDR + 4*i, for i in 0..N_PORTS-1; other addresses SHALL be ignored.
REQ-009 A capture SHALL occur on a rising edge where memwrite=1, an address matches, halted=0 and timeout=0.
REQ-010 A capture SHALL push {port index, writedata} into the FIFO and be visible at rd_data/rd_port/empty/count after that edge.
REQ-011 FIFO SHALL be first-word-fall-through: rd_data/rd_port show the oldest entry whenever empty=0; values SHALL be don't-care when empty=1.
REQ-012 A pop SHALL occur on a rising edge with rd_en=1 and empty=0; rd_en with empty=1 SHALL have no effect and no error flag.
REQ-013 Simultaneous capture and pop SHALL both take effect; count unchanged; legal even when full.
REQ-014 Capture while full without a pop SHALL drop the data, leave the FIFO unchanged and set overflow.
REQ-015 Simultaneous capture and rd_en while empty SHALL push only; count becomes 1.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH; count SHALL track 0..DEPTH exactly; full = (count==DEPTH), empty = (count==0).
REQ-017 A capture to HALT_PORT SHALL be stored normally and SHALL set halted on the same edge; later writes SHALL be ignored.
REQ-018 cycle_count SHALL increment by 1 each edge while halted=0 and timeout=0, and freeze otherwise.
REQ-019 timeout SHALL set on the edge where cycle_count would reach TIMEOUT; cycle_count then holds TIMEOUT; captures stop.
REQ-020 If the halt capture and the timeout condition fall on the same edge, halted SHALL win: the write is captured, halted=1, timeout stays 0.
REQ-021 Pops SHALL remain legal after halt or timeout, so the FIFO can be drained.
REQ-022 overflow, halted and timeout SHALL clear only on reset.

Reset
REQ-023 reset=1 at a rising edge SHALL set count=0, empty=1, full=0, overflow=0, halted=0, timeout=0, cycle_count=0 and both pointers to 0.
REQ-024 reset SHALL take priority over any capture or pop on the same edge, including mid-operation with a partly filled FIFO.
REQ-025 FIFO storage contents need not be cleared by reset.

Verification
REQ-026 Bench SHALL cover: reset, then a store to 0x4 with data 0x11 -> next cycle empty=0, count=1, rd_port=1, rd_data=0x11, halted=0.
REQ-027 Bench SHALL cover: 9 stores to 0x8 (data 1..9), no pops, DEPTH=8 -> full=1, count=8, overflow=1; draining 8 pops yields data 1..8 in order, then empty=1.
REQ-028 Bench SHALL cover: FIFO full and a capture with rd_en on the same edge -> count stays 8, overflow stays 0, new value appears after 7 more pops.
REQ-029 Bench SHALL cover: store 0x2A to 0x0 (HALT_PORT=0) -> halted=1 next cycle, entry {0,0x2A} stored, a following store to 0x4 is not captured, cycle_count frozen.
REQ-030 Bench SHALL cover: TIMEOUT=5 and no stores -> timeout=1 after 5 edges with cycle_count=5; a later store to 0x4 is not captured.
REQ-031 Bench SHALL cover: reset asserted with count=3 and overflow=1 -> one edge later count=0, empty=1, overflow=0.
